// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier for signed operands.
// One Booth step per clock. A result is ready WIDTH cycles after start is
// accepted, and a new start can be accepted every WIDTH+2 cycles.
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst          - synchronous active-high reset
//   start        - request a multiplication; only sampled in IDLE
//   multiplicand - signed M, captured on the accepting edge
//   multiplier   - signed Q, captured on the accepting edge
//   busy         - high in RUN and DONE
//   done         - one-cycle pulse while in DONE
//   product      - signed M*Q; updated on entry to DONE and held until then
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   acc;      // one guard bit so M = -2^(WIDTH-1) cannot overflow
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_1_next;

  // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,Q_1}
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    sum   = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          q_1   <= q_1_next;
          count <= count - CW'(1);
          // Final step: publish the result in the same edge that enters DONE
          if (count == CW'(1)) begin
            product <= {acc_next[WIDTH-1:0], q_next};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed checks of booth_mult_seq at WIDTH=8 plus a
// continuous-start sweep at WIDTH=16 against a signed multiply model.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  mc8 = '0;
  logic [7:0]  mq8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;

  logic        start16 = 1'b0;
  logic [15:0] mc16 = '0;
  logic [15:0] mq16 = '0;
  logic        busy16;
  logic        done16;
  logic [31:0] prod16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .multiplicand(mc8), .multiplier(mq8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .multiplicand(mc16), .multiplier(mq16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=8 operation, scramble operands after acceptance, wait for done
  task automatic run8(input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] p, output int lat, output int bcyc);
    mc8 = m; mq8 = q; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    mc8 = m ^ 8'h5A;
    mq8 = ~q;
    lat = 0;
    bcyc = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
      if (busy8) bcyc++;
    end
    p = prod8;
    if (done8) begin
      tick();
      if (busy8) bcyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; start16 = 1'b1; mc8 = 8'd7; mq8 = 8'hFD;
    tick();
    tick();
    tests_run++;
    if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    tests_run++;
    if (done8 !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done8); end
    tests_run++;
    if (prod8 !== 16'h0000) begin tests_failed++; $display("FAIL reset_product: got %h expected 0000", prod8); end
    tests_run++;
    if (busy16 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
    tick();
    tests_run++;
    if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL reset_priority_busy: got %b expected 0", busy8); end
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int lat, bcyc;
    run8(8'd7, 8'hFD, p, lat, bcyc);
    tests_run++;
    if (p !== 16'hFFEB) begin tests_failed++; $display("FAIL basic_product: got %h expected ffeb", p); end
    tests_run++;
    if (lat !== 8) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    tests_run++;
    if (bcyc !== 9) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected 9", bcyc); end
    tests_run++;
    if (prod8 !== 16'hFFEB) begin tests_failed++; $display("FAIL basic_product_hold: got %h expected ffeb", prod8); end
  endtask

  task automatic test_corners();
    logic [7:0]  tm [8] = '{8'h80, 8'h80, 8'h01, 8'h7F, 8'hFF, 8'h7F, 8'h80, 8'hFA};
    logic [7:0]  tq [8] = '{8'h80, 8'h7F, 8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h01, 8'h0B};
    logic [15:0] te [8] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h3F01,
                            16'h0001, 16'hC080, 16'hFF80, 16'hFFBE};
    logic [15:0] p;
    logic [7:0]  r;
    int lat, bcyc;
    for (int i = 0; i < 8; i++) begin
      run8(tm[i], tq[i], p, lat, bcyc);
      tests_run++;
      if (p !== te[i] || lat !== 8) begin
        tests_failed++;
        $display("FAIL corner_%0d: got %h lat %0d expected %h lat 8", i, p, lat, te[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom_range(1, 255));
      if (i < 5) run8(8'h00, r, p, lat, bcyc);
      else       run8(r, 8'h00, p, lat, bcyc);
      tests_run++;
      if (p !== 16'h0000) begin
        tests_failed++;
        $display("FAIL zero_%0d: partner %h got %h expected 0000", i, r, p);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [15:0] p = '0;
    mc8 = 8'd5; mq8 = 8'd6; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start8 = (c == 3 || c == 8);
      tick();
      if (done8) begin ndone++; p = prod8; end
    end
    start8 = 1'b0;
    tests_run++;
    if (ndone !== 1) begin tests_failed++; $display("FAIL ignore_start_done_count: got %0d expected 1", ndone); end
    tests_run++;
    if (p !== 16'h001E) begin tests_failed++; $display("FAIL ignore_start_product: got %h expected 001e", p); end
    tests_run++;
    if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL ignore_start_idle: got busy %b expected 0", busy8); end
  endtask

  task automatic test_reset_midrun();
    int ndone = 0;
    logic [15:0] p;
    int lat, bcyc;
    mc8 = 8'd7; mq8 = 8'hFD; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midrun_reset: got busy %b done %b product %h expected 0 0 0000", busy8, done8, prod8);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done8) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin tests_failed++; $display("FAIL midrun_no_done: got %0d expected 0", ndone); end
    run8(8'hFA, 8'h0B, p, lat, bcyc);
    tests_run++;
    if (p !== 16'hFFBE || lat !== 8) begin
      tests_failed++;
      $display("FAIL midrun_restart: got %h lat %0d expected ffbe lat 8", p, lat);
    end
  endtask

  // start16 held high; operands change every cycle, the pair present on every
  // 18th edge is the one accepted
  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [31:0] expq [$];
    logic [31:0] e;
    int last_done = -1;
    int ndone = 0;
    for (int cyc = 0; cyc < N * 18; cyc++) begin
      mc16 = 16'($urandom);
      mq16 = 16'($urandom);
      start16 = 1'b1;
      if (cyc % 18 == 0) begin
        e = $signed(mc16) * $signed(mq16);
        expq.push_back(e);
      end
      tick();
      if (done16) begin
        ndone++;
        e = (expq.size() > 0) ? expq.pop_front() : 32'hxxxxxxxx;
        tests_run++;
        if (prod16 !== e) begin
          tests_failed++;
          $display("FAIL sweep_product_%0d: got %h expected %h", ndone, prod16, e);
        end
        tests_run++;
        if ((last_done < 0 && cyc !== 16) || (last_done >= 0 && cyc - last_done !== 18)) begin
          tests_failed++;
          $display("FAIL sweep_spacing_%0d: got done at %0d previous %0d expected 18 apart", ndone, cyc, last_done);
        end
        last_done = cyc;
      end
    end
    start16 = 1'b0;
    tests_run++;
    if (ndone !== N) begin tests_failed++; $display("FAIL sweep_done_count: got %0d expected %0d", ndone, N); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
